// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Serialises command bytes from motor_commander into asynchronous UART frames
// (start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits).
// Bit timing is derived from the system clock: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> an even-parity bit (XOR of the byte) is sent between data and stop
//   undefined -> plain 8N1 / 8N2 framing, no parity logic
//
// Handshake: a byte transfers on a rising clk edge where uart_tx_valid and
// uart_tx_ready are both high; uart_tx_data is captured at that edge only.
// uart_tx_ready is high only in IDLE and never while reset is asserted.
module uart_tx_serializer #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_tx_valid,
   input  logic [7:0] uart_tx_data,
   output logic       uart_tx_ready,
   output logic       serial_out
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_tx_serializer: CLK_FREQ / BAUD_RATE must be at least 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
      end
   endgenerate

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;    // clocks elapsed within the current bit
   logic [2:0]       bit_idx;    // data bit index, reused as stop bit index
   logic [7:0]       shift_reg;  // remaining data bits, LSB is on the line
`ifdef UART_PARITY_EN
   logic             parity_bit;
`endif
   logic             bit_end;

   // Last clock of the current bit period; the counter reloads here, so
   // every bit is exactly CLKS_PER_BIT long and no drift accumulates.
   assign bit_end = (bit_cnt == CNT_LAST);

   // Ready only when idle and out of reset.
   assign uart_tx_ready = (state == IDLE) && !reset;

   // Frame sequencer; serial_out is a flop so the line never glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         serial_out <= 1'b1;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
`ifdef UART_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (state != IDLE) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               serial_out <= 1'b1;
               bit_cnt    <= '0;
               bit_idx    <= '0;
               if (uart_tx_valid) begin
                  shift_reg  <= uart_tx_data;
`ifdef UART_PARITY_EN
                  parity_bit <= ^uart_tx_data;
`endif
                  serial_out <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  state      <= DATA;
                  serial_out <= shift_reg[0];
                  bit_idx    <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef UART_PARITY_EN
                     state      <= PARITY;
                     serial_out <= parity_bit;
`else
                     state      <= STOP;
                     serial_out <= 1'b1;
`endif
                  end else begin
                     bit_idx    <= bit_idx + 3'd1;
                     shift_reg  <= {1'b0, shift_reg[7:1]};
                     serial_out <= shift_reg[1];
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state      <= STOP;
                  serial_out <= 1'b1;
                  bit_idx    <= '0;
               end
            end
`endif
            STOP: begin
               serial_out <= 1'b1;
               if (bit_end) begin
                  if (bit_idx == STOP_LAST) begin
                     state <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               serial_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Directed bench for uart_tx_serializer at CLKS_PER_BIT = 4 (400 Hz / 100 baud).
// Built with UART_PARITY_EN defined, it runs with STOP_BITS = 2 and checks the
// parity bit; otherwise it runs 8N1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_serializer;

   localparam int CF  = 400;
   localparam int BR  = 100;
   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int SB = 2;
   localparam int PB = 1;
`else
   localparam int SB = 1;
   localparam int PB = 0;
`endif
   localparam int NBITS = 10 + SB - 1 + PB;
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_tx_valid = 1'b0;
   logic [7:0] uart_tx_data = 8'h00;
   logic       uart_tx_ready;
   logic       serial_out;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   uart_tx_serializer #(
      .CLK_FREQ (CF),
      .BAUD_RATE(BR),
      .STOP_BITS(SB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .uart_tx_valid(uart_tx_valid),
      .uart_tx_data (uart_tx_data),
      .uart_tx_ready(uart_tx_ready),
      .serial_out   (serial_out)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level for frame bit slot idx of byte b
   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PB == 1 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic wait_ready(input int budget);
      int n = 0;
      while (uart_tx_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", {31'd0, uart_tx_ready}, 32'd1);
   endtask

   // Caller has driven valid/data; the accepting posedge precedes the first
   // negedge here. Checks every line sample of the frame, counts ready-low
   // cycles, decodes mid-bit like a receiver, then checks one idle cycle.
   task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_data,
                            input int pulse_at, output int start_cyc,
                            output logic [7:0] rx_byte, output logic rx_par);
      int low_cnt = 0;
      rx_byte = 8'h00;
      rx_par  = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start_cyc     = cyc;
            uart_tx_valid = hold;
            uart_tx_data  = next_data;
         end
         if (k == pulse_at) begin
            uart_tx_valid = 1'b1;
            uart_tx_data  = 8'hFF;
         end else if (pulse_at >= 0 && k == pulse_at + 1) begin
            uart_tx_valid = 1'b0;
         end
         check($sformatf("line_%02h_k%0d", b, k), {31'd0, serial_out}, {31'd0, exp_bit(b, k / CPB)});
         if (uart_tx_ready === 1'b0) low_cnt++;
         if (k % CPB == CPB / 2) begin
            if (k / CPB >= 1 && k / CPB <= 8) rx_byte[k / CPB - 1] = serial_out;
            if (PB == 1 && k / CPB == 9) rx_par = serial_out;
         end
      end
      check("ready_low_len", low_cnt, FRAME);
      @(negedge clk);
      check("idle_ready", {31'd0, uart_tx_ready}, 32'd1);
      check("idle_line", {31'd0, serial_out}, 32'd1);
   endtask

   task automatic check_quiet(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (serial_out !== 1'b1 || uart_tx_ready !== 1'b1) bad++;
      end
      check(tag, bad, 0);
   endtask

   initial begin
      int         s1, s2;
      logic [7:0] rx;
      logic       par;

      // 1. reset held with valid high
      reset         = 1'b1;
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_line", {31'd0, serial_out}, 32'd1);
         check("rst_ready", {31'd0, uart_tx_ready}, 32'd0);
      end
      reset         = 1'b0;
      uart_tx_valid = 1'b0;
      #1;
      check("ready_after_release", {31'd0, uart_tx_ready}, 32'd1);
      check_quiet("no_frame_after_reset", 3);

      // 2. single byte 'F'
      wait_ready(10);
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'h46;
      run_frame(8'h46, 1'b0, 8'h3C, -1, s1, rx, par);
      check("rx_F", rx, 8'h46);
`ifdef UART_PARITY_EN
      // 6. parity with two stop bits: 0x46 has three ones
      check("parity_F", {31'd0, par}, 32'd1);
      check("parity_err_F", {31'd0, par ^ (^rx)}, 32'd0);
`endif

      // 4. busy pulse of 0xFF during an 'F' frame is ignored
      wait_ready(10);
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'h46;
      run_frame(8'h46, 1'b0, 8'h00, 10, s1, rx, par);
      check("rx_F_busy", rx, 8'h46);
      check_quiet("no_second_frame", FRAME);

      // 3. back-to-back 'L' then 'R' with valid held
      wait_ready(10);
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'h4C;
      run_frame(8'h4C, 1'b1, 8'h52, -1, s1, rx, par);
      check("rx_L", rx, 8'h4C);
      run_frame(8'h52, 1'b0, 8'h00, -1, s2, rx, par);
      check("rx_R", rx, 8'h52);
      check("start_gap", s2 - s1, FRAME + 1);

      // 5. reset during data bit 3 of 'S' (bit 3 of 0x53 is 0)
      wait_ready(10);
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'h53;
      @(negedge clk);
      uart_tx_valid = 1'b0;
      uart_tx_data  = 8'h00;
      repeat (17) @(negedge clk);
      check("S_bit3_low", {31'd0, serial_out}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_line", {31'd0, serial_out}, 32'd1);
      check("abort_ready", {31'd0, uart_tx_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("abort_ready_release", {31'd0, uart_tx_ready}, 32'd1);
      check_quiet("no_resume", 2 * FRAME);
      wait_ready(10);
      uart_tx_valid = 1'b1;
      uart_tx_data  = 8'h46;
      run_frame(8'h46, 1'b0, 8'h99, -1, s1, rx, par);
      check("rx_F_after_abort", rx, 8'h46);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
